bp_gshare_btb: RTL and testbench
================================

# bp_gshare_btb

Parametrised two-level dynamic branch predictor with a branch target buffer, sitting in the fetch stage beside the PC register. It predicts direction from a table of 2-bit saturating counters, indexed either by PC alone (bimodal) or by PC XOR global history (gshare), and supplies the target from a direct-mapped tagged BTB. It is trained by resolved-branch updates from execute and clears its own tables after reset with a sweep state machine.

## Interface
- PC_W, 32, PC width in bits
- IDX_W, 6, log2 of the pattern history table (PHT) entry count
- GHR_W, 6, global history length; must be ≤ IDX_W
- BTB_IDX_W, 4, log2 of the BTB entry count
- MODE, 1, 0 = bimodal (PC index only), 1 = gshare (PC XOR GHR)
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock, all state on the rising edge
- rst  in  1  synchronous active-high reset
- ready  out  1  tables initialised; lookups and updates are accepted
- lookup_valid  in  1  request a prediction
- lookup_pc  in  PC_W  fetch PC
- pred_valid  out  1  prediction outputs valid this cycle
- pred_hit  out  1  BTB tag match
- pred_taken  out  1  predicted taken
- pred_target  out  PC_W  predicted next PC
- upd_valid  in  1  resolved-branch update
- upd_pc  in  PC_W  PC of the resolved branch
- upd_taken  in  1  actual direction
- upd_target  in  PC_W  actual taken target

## Operation
- PC index bits: PHT uses pc[IDX_W+1:2]; BTB uses pc[BTB_IDX_W+1:2]; BTB tag is pc[PC_W-1:BTB_IDX_W+2].
- PHT index: MODE=0 uses the PC index. MODE=1 uses the PC index XOR the GHR, zero-extended to IDX_W.
- FSM states: INIT and RUN.
  - rst forces INIT with sweep counter = 0. Every cycle in INIT writes PHT[cnt] = 2'b01 (weakly not-taken), clears BTB valid[cnt], and sets GHR = 0.
  - The sweep covers 2^max(IDX_W,BTB_IDX_W) entries. The transition to RUN happens after the last entry is written.
- ready = 1 only in RUN. Requests made while ready = 0 are ignored.
- Lookup result:
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & counter[1].
  - pred_target = BTB target when pred_taken, otherwise lookup_pc + 4 (modulo 2^PC_W).
- Update, RUN state only:
  - The PHT entry at the index formed from upd_pc and the current GHR saturates up on taken and down on not-taken (0..3).
  - The GHR then shifts left and inserts upd_taken at bit 0.
  - On taken, the BTB entry is overwritten with valid = 1, the tag and upd_target; a different tag is evicted.
  - A not-taken update never allocates and never invalidates an entry.

## Timing
- Reset values: ready = 0, pred_valid = 0, pred_hit = 0, pred_taken = 0, pred_target = 0.
- ready rises 2^max(IDX_W,BTB_IDX_W) cycles after the first cycle with rst low.
- Lookup latency is 1 cycle: the request at edge N produces registered outputs after edge N+1, with pred_valid high for exactly one cycle per request. Back-to-back lookups give one result per cycle.
- Updates take effect at the edge where they are sampled.
- A lookup and an update in the same cycle:
  - The lookup reads pre-update PHT, BTB and GHR state (read-before-write).
  - A lookup on the following cycle sees the update.
- rst asserted mid-operation: on the next edge the block returns to INIT, outputs go to their reset values, and any pending result is dropped.
- Counter saturation: a taken update at 3 stays 3; a not-taken update at 0 stays 0.

## Structure
- Package bp_pkg holds:
  - counter typedef (2-bit);
  - constants CNT_WEAK_NT = 2'b01 and PC_STEP = 4;
  - FSM state enum {INIT, RUN}.
- Sub-module bp_sat_counter: the 2-bit saturating next-state function. It is instanced in the update path.
- Tables are plain arrays in the top level; there is no separate memory module.

## Test plan
- Reset: pulse rst 1 cycle. Required: ready low for 64 cycles, then high. Lookup 0x400 then returns pred_valid = 1, hit = 0, taken = 0, target = 0x404.
- Train (MODE=0): two taken updates on 0x400 with target 0x800. Required: lookup 0x400 returns hit = 1, taken = 1, target = 0x800.
- Hysteresis (MODE=0): three taken updates on 0x400, then one not-taken. Required: still taken. After a second not-taken: taken = 0, hit = 1, target = 0x404.
- BTB alias: train 0x400 taken to 0x800, then update 0x440 taken to 0x900 (same BTB index, different tag). Required: lookup 0x400 gives hit = 0; lookup 0x440 gives target 0x900.
- Gshare (MODE=1): 16 alternating T/N updates on 0x400 with target 0x800. Required: the lookup after a T update predicts not-taken, and the lookup after an N update predicts taken.
- Corner cases:
  - Lookup and update of 0x400 in the same cycle: the result reflects the old state.
  - rst during RUN: pred_valid = 0 on the next cycle, and ready stays low for 64 cycles.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and constants for the gshare/bimodal branch predictor.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t        CNT_WEAK_NT = 2'b01;
  localparam int unsigned PC_STEP     = 4;

  typedef enum logic {INIT, RUN} state_e;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state function used to train the PHT.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != 2'b11) cnt_o = ctr_t'(cnt_i + 2'd1);
    end else begin
      if (cnt_i != 2'b00) cnt_o = ctr_t'(cnt_i - 2'd1);
    end
  end

endmodule

// File: rtl/bp_gshare_btb.sv
// Fetch-stage direction predictor (bimodal or gshare PHT) with a direct-mapped tagged BTB.
// Tables are swept to a known state after reset before lookups and updates are accepted.
module bp_gshare_btb
  import bp_pkg::*;
#(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned GHR_W     = 6,
  parameter int unsigned BTB_IDX_W = 4,
  parameter int unsigned MODE      = 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic            lookup_valid,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_valid,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target
);

  localparam int unsigned SWP_W = (IDX_W > BTB_IDX_W) ? IDX_W : BTB_IDX_W;
  localparam int unsigned TAG_W = PC_W - BTB_IDX_W - 2;
  localparam int unsigned PHT_N = 1 << IDX_W;
  localparam int unsigned BTB_N = 1 << BTB_IDX_W;

  state_e           state_q, state_d;
  logic [SWP_W-1:0] swp_q, swp_d;
  logic [GHR_W-1:0] ghr_q;

  ctr_t             pht_q       [PHT_N];
  logic [BTB_N-1:0] btb_valid_q;
  logic [TAG_W-1:0] btb_tag_q   [BTB_N];
  logic [PC_W-1:0]  btb_tgt_q   [BTB_N];

  logic [IDX_W-1:0]     lk_pidx, up_pidx;
  logic [BTB_IDX_W-1:0] lk_bidx, up_bidx;
  logic [TAG_W-1:0]     lk_tag, up_tag;
  logic                 lk_hit, lk_taken;
  logic [PC_W-1:0]      lk_target;
  logic [1:0]           up_cnt_d;

  assign ready = (state_q == RUN);

  // History is only folded into the index in gshare mode.
  assign lk_pidx = lookup_pc[IDX_W+1:2] ^ ((MODE != 0) ? IDX_W'(ghr_q) : '0);
  assign up_pidx = upd_pc[IDX_W+1:2] ^ ((MODE != 0) ? IDX_W'(ghr_q) : '0);
  assign lk_bidx = lookup_pc[BTB_IDX_W+1:2];
  assign up_bidx = upd_pc[BTB_IDX_W+1:2];
  assign lk_tag  = lookup_pc[PC_W-1:BTB_IDX_W+2];
  assign up_tag  = upd_pc[PC_W-1:BTB_IDX_W+2];

  assign lk_hit    = btb_valid_q[lk_bidx] && (btb_tag_q[lk_bidx] == lk_tag);
  assign lk_taken  = lk_hit && pht_q[lk_pidx][1];
  assign lk_target = lk_taken ? btb_tgt_q[lk_bidx] : lookup_pc + PC_W'(PC_STEP);

  logic unused_upd_pc;
  assign unused_upd_pc = ^upd_pc[1:0];

  bp_sat_counter u_sat_counter (
    .cnt_i   (pht_q[up_pidx]),
    .taken_i (upd_taken),
    .cnt_o   (up_cnt_d)
  );

  always_comb begin
    state_d = state_q;
    swp_d   = swp_q;
    case (state_q)
      INIT: begin
        swp_d = swp_q + SWP_W'(1);
        if (&swp_q) state_d = RUN;
      end
      RUN: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      swp_q       <= '0;
      ghr_q       <= '0;
      pred_valid  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else begin
      state_q    <= state_d;
      swp_q      <= swp_d;
      pred_valid <= ready && lookup_valid;
      if (ready && lookup_valid) begin
        pred_hit    <= lk_hit;
        pred_taken  <= lk_taken;
        pred_target <= lk_target;
      end
      if (state_q == INIT) begin
        ghr_q <= '0;
      end else if (upd_valid) begin
        ghr_q <= GHR_W'({ghr_q, upd_taken});
      end
    end
  end

  // Lookups above read these arrays combinationally, so same-cycle updates are read-before-write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) begin
        pht_q[swp_q[IDX_W-1:0]]           <= CNT_WEAK_NT;
        btb_valid_q[swp_q[BTB_IDX_W-1:0]] <= 1'b0;
      end else if (upd_valid) begin
        pht_q[up_pidx] <= up_cnt_d;
        if (upd_taken) begin
          btb_valid_q[up_bidx] <= 1'b1;
          btb_tag_q[up_bidx]   <= up_tag;
          btb_tgt_q[up_bidx]   <= upd_target;
        end
      end
    end
  end

endmodule

// File: tb/tb_bp_gshare_btb.sv
// Directed bench for bp_gshare_btb: a bimodal and a gshare instance share one stimulus stream.
module tb_bp_gshare_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid, upd_valid, upd_taken;
  logic [31:0] lookup_pc, upd_pc, upd_target;

  logic        b_ready, b_pred_valid, b_pred_hit, b_pred_taken;
  logic [31:0] b_pred_target;
  logic        g_ready, g_pred_valid, g_pred_hit, g_pred_taken;
  logic [31:0] g_pred_target;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_gshare_btb #(.MODE(0)) u_bim (
    .clk          (clk),
    .rst          (rst),
    .ready        (b_ready),
    .lookup_valid (lookup_valid),
    .lookup_pc    (lookup_pc),
    .pred_valid   (b_pred_valid),
    .pred_hit     (b_pred_hit),
    .pred_taken   (b_pred_taken),
    .pred_target  (b_pred_target),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target)
  );

  bp_gshare_btb #(.MODE(1)) u_gsh (
    .clk          (clk),
    .rst          (rst),
    .ready        (g_ready),
    .lookup_valid (lookup_valid),
    .lookup_pc    (lookup_pc),
    .pred_valid   (g_pred_valid),
    .pred_hit     (g_pred_hit),
    .pred_taken   (g_pred_taken),
    .pred_target  (g_pred_target),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target)
  );

  typedef struct {
    logic        lv;
    logic [31:0] lpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utg;
    logic        ehit;
    logic        etk;
    logic [31:0] etgt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic lv, logic [31:0] lpc, logic uv, logic [31:0] upc, logic ut,
                              logic [31:0] utg, logic ehit, logic etk, logic [31:0] etgt);
    vec_t v;
    v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg;
    v.ehit = ehit; v.etk = etk; v.etgt = etgt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    lookup_valid = 1'b0; lookup_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until ready rises; returns also any pred_valid seen meanwhile.
  task automatic wait_ready(output int n, output int spurious);
    n = 0;
    spurious = 0;
    while (!b_ready && n < 200) begin
      tick();
      n++;
      if (b_pred_valid || g_pred_valid) spurious++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL sim_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n, sp;
    logic et;

    // Bimodal vectors: one cycle per row, outputs checked after the following edge.
    tbl.push_back(mk(1, 32'h400, 0, 0, 0, 0, 0, 0, 32'h404));
    tbl.push_back(mk(0, 0, 1, 32'h400, 1, 32'h800, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h400, 1, 32'h800, 0, 0, 0));
    tbl.push_back(mk(1, 32'h400, 0, 0, 0, 0, 1, 1, 32'h800));
    tbl.push_back(mk(0, 0, 1, 32'h400, 1, 32'h800, 0, 0, 0));
    tbl.push_back(mk(1, 32'h400, 1, 32'h400, 0, 0, 1, 1, 32'h800));
    tbl.push_back(mk(1, 32'h400, 0, 0, 0, 0, 1, 1, 32'h800));
    tbl.push_back(mk(0, 0, 1, 32'h400, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h400, 0, 0, 0, 0, 1, 0, 32'h404));
    tbl.push_back(mk(0, 0, 1, 32'h400, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h400, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h400, 1, 32'h800, 0, 0, 0));
    tbl.push_back(mk(1, 32'h400, 0, 0, 0, 0, 1, 0, 32'h404));
    tbl.push_back(mk(0, 0, 1, 32'h400, 1, 32'h800, 0, 0, 0));
    tbl.push_back(mk(1, 32'h400, 0, 0, 0, 0, 1, 1, 32'h800));
    tbl.push_back(mk(0, 0, 1, 32'h440, 1, 32'h900, 0, 0, 0));
    tbl.push_back(mk(1, 32'h400, 0, 0, 0, 0, 0, 0, 32'h404));
    tbl.push_back(mk(1, 32'h440, 0, 0, 0, 0, 1, 1, 32'h900));
    tbl.push_back(mk(0, 0, 1, 32'h440, 0, 32'h123, 0, 0, 0));
    tbl.push_back(mk(1, 32'h440, 0, 0, 0, 0, 1, 0, 32'h444));
    tbl.push_back(mk(0, 0, 1, 32'h400, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h440, 0, 0, 0, 0, 1, 0, 32'h444));
    tbl.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_outputs", 64'({b_ready, b_pred_valid, b_pred_hit, b_pred_taken, b_pred_target}), 64'd0);
    chk("rst_ready_gsh", 64'(g_ready), 64'd0);
    rst = 1'b0;
    wait_ready(n, sp);
    chk("init_sweep_cycles", 64'(n), 64'd64);
    chk("gsh_ready", 64'(g_ready), 64'd1);

    foreach (tbl[i]) begin
      lookup_valid = tbl[i].lv; lookup_pc = tbl[i].lpc;
      upd_valid = tbl[i].uv; upd_pc = tbl[i].upc;
      upd_taken = tbl[i].ut; upd_target = tbl[i].utg;
      tick();
      chk($sformatf("row%0d_valid", i), 64'(b_pred_valid), 64'(tbl[i].lv));
      if (tbl[i].lv)
        chk($sformatf("row%0d_pred", i), 64'({b_pred_hit, b_pred_taken, b_pred_target}),
            64'({tbl[i].ehit, tbl[i].etk, tbl[i].etgt}));
    end
    idle_inputs();

    // Reset in RUN with a lookup pending; requests during the sweep must be ignored.
    rst = 1'b1;
    lookup_valid = 1'b1; lookup_pc = 32'h440;
    tick();
    chk("midrst_outputs", 64'({b_ready, b_pred_valid, b_pred_hit, b_pred_taken, b_pred_target}),
        64'd0);
    chk("midrst_gsh_valid", 64'(g_pred_valid), 64'd0);
    rst = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'h440; upd_taken = 1'b1; upd_target = 32'h900;
    wait_ready(n, sp);
    chk("midrst_sweep_cycles", 64'(n), 64'd64);
    chk("init_requests_ignored", 64'(sp), 64'd0);
    idle_inputs();
    lookup_valid = 1'b1; lookup_pc = 32'h440;
    tick();
    chk("post_rst_bim", 64'({b_pred_valid, b_pred_hit, b_pred_taken, b_pred_target}),
        64'({1'b1, 1'b0, 1'b0, 32'h444}));
    chk("post_rst_gsh", 64'({g_pred_valid, g_pred_hit, g_pred_taken, g_pred_target}),
        64'({1'b1, 1'b0, 1'b0, 32'h444}));
    idle_inputs();

    // Alternating T/N on 0x400: the pattern is learnt once history reaches 21/42 (from update 7).
    for (int k = 1; k <= 16; k++) begin
      upd_valid = 1'b1; upd_pc = 32'h400; upd_taken = k[0]; upd_target = 32'h800;
      tick();
      idle_inputs();
      lookup_valid = 1'b1; lookup_pc = 32'h400;
      tick();
      lookup_valid = 1'b0;
      et = (k >= 8) && !k[0];
      chk($sformatf("gshare_k%0d", k), 64'({g_pred_valid, g_pred_hit, g_pred_taken, g_pred_target}),
          64'({1'b1, 1'b1, et, et ? 32'h800 : 32'h404}));
    end
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
